// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-side control: reset PC default,
// sequential PC increment and the PC sequencer state encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational PC target arithmetic: sequential PC+4, branch target
// (PC+4 of branch plus word-scaled offset) and jump target (region concat).
// All adds are 32-bit modulo 2^32.
module pc_target_gen
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] branch_pc4_i,
  input  logic [31:0] branch_imm_i,
  input  logic [31:0] jump_pc4_i,
  input  logic [25:0] jump_idx_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] branch_tgt_o,
  output logic [31:0] jump_tgt_o
);

  logic [31:0] branch_off;
  logic        unused_bits;

  // imm[31:30] fall off the top of the shift; only the region bits of the
  // jump's PC+4 are kept.
  assign unused_bits  = ^{branch_imm_i[31:30], jump_pc4_i[27:0]};

  assign branch_off   = {branch_imm_i[29:0], 2'b00};
  assign pc_plus4_o   = pc_i + PC_INC;
  assign branch_tgt_o = branch_pc4_i + branch_off;
  assign jump_tgt_o   = {jump_pc4_i[31:28], jump_idx_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller for the 5-stage pipeline: owns the PC register,
// picks the next PC (branch > jump > stall > sequential), drives the
// IF/ID and ID/EX flushes and counts redirects with a saturating counter.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// BOOT     | first cycle after reset; PC holds RESET_PC, fetch is a bubble
// RUN      | normal fetch; branch/jump redirects evaluated here
// REDIRECT | cycle after a redirect; branch/jump masked, stall still honoured
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_ex_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_pc4_i,
  input  logic [31:0]      branch_imm_i,
  input  logic             jump_id_i,
  input  logic [31:0]      jump_pc4_i,
  input  logic [25:0]      jump_idx_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             fetch_valid_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  seq_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      branch_tgt;
  logic [31:0]      jump_tgt;
  logic             redirect;
  logic             flush_ifid;
  logic             flush_idex;

  pc_target_gen u_tgt (
    .pc_i         (pc_q),
    .branch_pc4_i (branch_pc4_i),
    .branch_imm_i (branch_imm_i),
    .jump_pc4_i   (jump_pc4_i),
    .jump_idx_i   (jump_idx_i),
    .pc_plus4_o   (pc_plus4),
    .branch_tgt_o (branch_tgt),
    .jump_tgt_o   (jump_tgt)
  );

  // State, PC and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, next-PC priority mux and flush decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        // A taken branch beats a stalled or unstalled jump: the jump sits
        // on the wrong path behind the branch.
        if (branch_ex_i && branch_taken_i) begin
          pc_d       = branch_tgt;
          redirect   = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = REDIRECT;
        end else if (jump_id_i && !stall_i) begin
          pc_d       = jump_tgt;
          redirect   = 1'b1;
          flush_ifid = 1'b1;
          state_d    = REDIRECT;
        end else if (!stall_i) begin
          pc_d = pc_plus4;
        end
      end
      REDIRECT: begin
        state_d = RUN;
        if (!stall_i) pc_d = pc_plus4;
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // Saturating redirect counter.
  always_comb begin
    cnt_d = cnt_q;
    if (redirect && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_plus4;
  assign fetch_valid_o  = (state_q != BOOT);
  assign flush_ifid_o   = flush_ifid && !rst_i;
  assign flush_idex_o   = flush_idex && !rst_i;
  assign redirect_cnt_o = cnt_q;

endmodule
